// File: rtl/uart_ctrl.sv
// uart_ctrl: bus-mapped UART sequencer. Generates the receiver oversample
// tick (sig16) and transmitter bit tick (sig), queues CPU bytes for the
// transmitter behind a request/idle handshake, and holds received bytes with
// overrun detection and a level interrupt.
//
// Transmitter handshake: tx_en is a request level; the transmitter accepts
// by dropping tx_status (busy) and finishes by raising it again (idle).
// tx_data is only ever changed while the FSM sits in T_IDLE.
module uart_ctrl #(
  parameter int CLK_DIV16 = 27,
  parameter int TXQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Add,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        sig16,
  output logic        sig,
  input  logic        rx_status,
  input  logic [7:0]  rx_data,
  input  logic        tx_status,
  output logic        tx_en,
  output logic [7:0]  tx_data
);

  localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON = 32'h4000_0020;

  localparam int DW = (CLK_DIV16 > 2) ? $clog2(CLK_DIV16) : 1;
  localparam int AW = $clog2(TXQ_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV16 - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV16 / 2);
  localparam logic [AW:0]   Q_FULL   = (AW+1)'(TXQ_DEPTH);

  typedef enum logic [1:0] {T_IDLE, T_REQ, T_BUSY} tx_state_t;

  tx_state_t     state;
  logic [DW-1:0] div_cnt;
  logic [3:0]    cnt16;
  logic [7:0]    q_mem [TXQ_DEPTH];
  logic [AW-1:0] q_wr;
  logic [AW-1:0] q_rd;
  logic [AW:0]   q_cnt;
  logic          q_full;
  logic          q_empty;
  logic          push;
  logic          pop;
  logic          txd_wr;
  logic          con_wr;
  logic          rxd_rd;
  logic          tx_irq_en;
  logic          rx_irq_en;
  logic          tx_drop;
  logic          rx_overrun;
  logic          rx_valid;
  logic [7:0]    rx_buf;
  logic          rx_s1;
  logic          rx_s2;
  logic          rx_s3;
  logic          rx_rise;
  logic          unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  assign txd_wr  = wr && (Add == ADDR_TXD);
  assign con_wr  = wr && (Add == ADDR_CON);
  assign rxd_rd  = rd && (Add == ADDR_RXD);
  assign q_full  = (q_cnt == Q_FULL);
  assign q_empty = (q_cnt == '0);
  assign push    = txd_wr && !q_full;
  assign pop     = (state == T_BUSY) && tx_status;
  assign rx_rise = rx_s2 && !rx_s3;
  assign sig     = cnt16[3];

  // Free-running divider: sig16 high for the upper half of each period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      cnt16   <= '0;
      sig16   <= 1'b0;
    end else begin
      sig16 <= (div_cnt >= DIV_HALF);
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        cnt16   <= cnt16 + 4'd1;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  // TX FIFO storage and occupancy; a full write is dropped and flagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TXQ_DEPTH; i++) q_mem[i] <= '0;
      q_wr  <= '0;
      q_rd  <= '0;
      q_cnt <= '0;
    end else begin
      if (push) begin
        q_mem[q_wr] <= wdata[7:0];
        q_wr        <= q_wr + AW'(1);
      end
      if (pop) q_rd <= q_rd + AW'(1);
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + (AW+1)'(1);
        2'b01:   q_cnt <= q_cnt - (AW+1)'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // Transmit sequencer with registered request and data outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= T_IDLE;
      tx_en   <= 1'b0;
      tx_data <= '0;
    end else begin
      case (state)
        T_IDLE: if (!q_empty) begin
          tx_data <= q_mem[q_rd];
          tx_en   <= 1'b1;
          state   <= T_REQ;
        end
        T_REQ: if (!tx_status) begin
          tx_en <= 1'b0;
          state <= T_BUSY;
        end
        T_BUSY: if (tx_status) state <= T_IDLE;
        default: begin
          tx_en <= 1'b0;
          state <= T_IDLE;
        end
      endcase
    end
  end

  // Control register bits and the two sticky error flags (set beats clear).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_irq_en  <= 1'b0;
      rx_irq_en  <= 1'b0;
      tx_drop    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (con_wr) begin
        tx_irq_en <= wdata[0];
        rx_irq_en <= wdata[1];
      end
      if (txd_wr && q_full)              tx_drop <= 1'b1;
      else if (con_wr && wdata[6])       tx_drop <= 1'b0;
      if (rx_rise && rx_valid && !rxd_rd) rx_overrun <= 1'b1;
      else if (con_wr && wdata[5])       rx_overrun <= 1'b0;
    end
  end

  // Receive path: synchronise the byte-valid level and capture on its rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1    <= 1'b0;
      rx_s2    <= 1'b0;
      rx_s3    <= 1'b0;
      rx_buf   <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_s1 <= rx_status;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      if (rx_rise) begin
        rx_buf   <= rx_data;
        rx_valid <= 1'b1;
      end else if (rxd_rd) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // Level interrupt, registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq <= 1'b0;
    else        irq <= (rx_irq_en && rx_valid) ||
                       (tx_irq_en && q_empty && (state == T_IDLE));
  end

  // Combinational read mux; zero whenever no read is in progress.
  always_comb begin
    rdata = '0;
    if (rd) begin
      case (Add)
        ADDR_RXD: rdata = {24'b0, rx_buf};
        ADDR_CON: rdata = {25'b0, tx_drop, rx_overrun, q_full, rx_valid,
                           q_empty, rx_irq_en, tx_irq_en};
        default:  rdata = '0;
      endcase
    end
  end

endmodule
